// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// State encoding, default width and counter sizing helper.
package serial_arith_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_fullsub_cell.sv
// Single-bit full subtractor, the only arithmetic in the block.
// Computes a - b - bin for one bit position.
module fullsub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bor
);

  assign diff = a ^ b ^ bin;
  assign bor  = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin over WIDTH cycles, LSB first,
// using one full-subtractor cell and a registered borrow.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bor
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bor_q, bor_d;

  logic cell_diff;
  logic cell_bor;

  fullsub_cell u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (borrow_q),
    .diff (cell_diff),
    .bor  (cell_bor)
  );

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    diff_sr_d = diff_sr_q;
    diff_d    = diff_q;
    cnt_d     = cnt_q;
    borrow_d  = borrow_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bor_d     = bor_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = bin;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sr_d    = a_sr_q >> 1;
        b_sr_d    = b_sr_q >> 1;
        // new bit enters at MSB; after WIDTH shifts bit 0 is the LSB
        diff_sr_d = WIDTH'({cell_diff, diff_sr_q} >> 1);
        borrow_d  = cell_bor;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d  = diff_sr_d;
          bor_d   = cell_bor;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      diff_q    <= '0;
      cnt_q     <= '0;
      borrow_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bor_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      diff_sr_q <= diff_sr_d;
      diff_q    <= diff_d;
      cnt_q     <= cnt_d;
      borrow_q  <= borrow_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bor_q     <= bor_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bor  = bor_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench: cycle model at WIDTH=8 plus directed and exhaustive
// WIDTH=4 checks against plain unsigned arithmetic.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, bor;
  logic [W-1:0] diff;

  logic       s4 = 1'b0;
  logic       bin4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic [3:0] d4;
  logic       busy4, done4, bor4;

  int pass_cnt = 0;
  int tot_cnt = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic         m_bor = 1'b0;
  logic [W-1:0] m_diff = '0;
  logic         p_bor = 1'b0;
  logic [W-1:0] p_diff = '0;
  int           rem = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bor(bor)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4),
    .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(d4), .bor(bor4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
  endtask

  // Transaction-level reference: result known at acceptance,
  // published WIDTH edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_bor = 1'b0;
      m_diff = '0;   rem = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        rem--;
        if (rem == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
          m_diff = p_diff; m_bor = p_bor;
        end
      end else if (start) begin
        p_diff = a - b - W'(bin);
        p_bor  = (int'(a) < int'(b) + int'(bin));
        m_busy = 1'b1;
        rem    = W;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("diff", diff, m_diff);
      chk("bor", bor, m_bor);
    end
  end

  // Returns cycles waited and busy cycles seen; called just after acceptance.
  task automatic wait_done(input string n, output int lat, output int nb);
    nb = 0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin lat = i; break; end
      if (busy) nb++;
      @(negedge clk);
    end
    if (lat < 0) chk({n, "_timeout"}, 0, 1);
  endtask

  task automatic op(input string n, input logic [W-1:0] ia,
                    input logic [W-1:0] ib, input logic ibin,
                    input logic [W-1:0] ed, input logic eb);
    int lat, nb;
    @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = '1; b = '0; bin = 1'b1;
    wait_done(n, lat, nb);
    chk({n, "_diff"}, diff, ed);
    chk({n, "_bor"}, bor, eb);
  endtask

  initial begin
    int lat, nb, c1, c2, dc;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bor", bor, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // basic: latency and busy width
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("basic", lat, nb);
    chk("basic_lat", lat, W);
    chk("basic_busy_cycles", nb, W);
    chk("basic_diff", diff, 8'h02);
    chk("basic_bor", bor, 0);
    @(negedge clk);
    chk("done_pulse_len", done, 0);
    chk("diff_hold", diff, 8'h02);

    op("z_minus_1", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    op("ff_ff_b1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    op("80_7f_b1", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
    op("c3_3c_b0", 8'hC3, 8'h3C, 1'b0, 8'h87, 1'b0);

    // start during RUN ignored
    @(negedge clk);
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dc = done_cnt;
    @(negedge clk);
    @(negedge clk);
    a = 8'hAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign", lat, nb);
    chk("ign_diff", diff, 8'h0F);
    chk("ign_bor", bor, 0);
    repeat (12) @(negedge clk);
    chk("ign_one_done", done_cnt - dc, 1);

    // back-to-back with start held high
    @(negedge clk);
    a = 8'h09; b = 8'h04; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h04; b = 8'h09;
    wait_done("b2b1", lat, nb);
    c1 = cyc;
    chk("b2b1_diff", diff, 8'h05);
    chk("b2b1_bor", bor, 0);
    @(negedge clk);
    wait_done("b2b2", lat, nb);
    c2 = cyc;
    start = 1'b0;
    chk("b2b2_diff", diff, 8'hFB);
    chk("b2b2_bor", bor, 1);
    chk("b2b_spacing", c2 - c1, W + 1);

    // asynchronous reset mid-operation
    @(negedge clk);
    a = 8'h33; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_diff", diff, 0);
    chk("arst_bor", bor, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dc = done_cnt;
    repeat (14) @(negedge clk);
    chk("arst_no_done", done_cnt - dc, 0);
    op("after_rst", 8'h33, 8'h11, 1'b0, 8'h22, 1'b0);

    // exhaustive WIDTH=4 against plain arithmetic
    for (int i = 0; i < 512; i++) begin
      int ea, eb, ec, k;
      ea = i & 15; eb = (i >> 4) & 15; ec = (i >> 8) & 1;
      @(negedge clk);
      a4 = 4'(ea); b4 = 4'(eb); bin4 = ec[0]; s4 = 1'b1;
      @(negedge clk);
      s4 = 1'b0;
      k = 0;
      while (!done4 && k < 10) begin
        @(negedge clk);
        k++;
      end
      if (!done4) chk("w4_timeout", 0, 1);
      chk("w4_diff", d4, (ea - eb - ec) & 15);
      chk("w4_bor", bor4, (ea < eb + ec) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
